// File: rtl/bus_pkg.sv
// Shared types for the bus arbiter: transfer size/type encodings and arbiter FSM states.
package bus_pkg;

    localparam int unsigned TSIZE_W = 2;

    typedef enum logic [TSIZE_W-1:0] {
        TSIZE_BYTE  = 2'd0,
        TSIZE_HALF  = 2'd1,
        TSIZE_WORD  = 2'd2,
        TSIZE_DWORD = 2'd3
    } tsize_e;

    typedef enum logic {
        TTYPE_READ  = 1'b0,
        TTYPE_WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: the first requester after `last` (wrapping) wins.
module rr_picker #(
    parameter  int unsigned NM = 2,
    localparam int unsigned IW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] winner,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned i = 1; i <= NM; i++) begin
            cand = IW'((32'(last) + i) % NM);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus among NM masters, one transaction at a time.
// Optional BUSY watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NM      = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    bclk,
    input  logic                    brst_n,
    input  logic [NM-1:0]           m_breq,
    input  logic [NM-1:0]           m_bstart,
    input  logic [NM*32-1:0]        m_addr,
    input  logic [NM*32-1:0]        m_wdata,
    input  logic [NM*TSIZE_W-1:0]   m_tsize,
    output logic [NM-1:0]           m_bgnt,
    output logic [NM-1:0]           m_bdone,
    output logic [NM-1:0]           m_berror,
    output logic [31:0]             m_rdata,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [TSIZE_W-1:0]      s_tsize,
    output logic                    s_bstart,
    output logic                    s_ss,
    input  logic [31:0]             s_rdata,
    input  logic                    s_bdone,
    input  logic                    s_berror
);

    localparam int unsigned IW = $clog2(NM);

    if (NM < 2 || NM > 8 || TIMEOUT == 0) begin : g_bad_params
        $error("bus_arbiter: NM must be 2..8 and TIMEOUT nonzero");
    end

    arb_state_e          state, state_nx;
    logic [IW-1:0]       gnt_idx, gnt_idx_nx;
    logic [IW-1:0]       last, last_nx;
    logic [NM-1:0]       bgnt_nx;
    logic [NM-1:0]       win_oh;
    logic [IW-1:0]       win_idx;
    logic                win_any;
    logic                finish;
    logic                fin_err;
    logic                tmo_hit;
    logic                others;

    logic [31:0]         addr_a  [NM];
    logic [31:0]         wdata_a [NM];
    logic [TSIZE_W-1:0]  tsize_a [NM];

    for (genvar i = 0; i < NM; i++) begin : g_unpack
        assign addr_a[i]  = m_addr[32*i +: 32];
        assign wdata_a[i] = m_wdata[32*i +: 32];
        assign tsize_a[i] = m_tsize[TSIZE_W*i +: TSIZE_W];
    end

    rr_picker #(
        .NM(NM)
    ) u_picker (
        .req     (m_breq),
        .last    (last),
        .winner  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    // Held at zero outside BUSY so every BUSY entry starts a fresh count.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            tmo_cnt <= '0;
        end else if (state != BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == BUSY) && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            state   <= IDLE;
            m_bgnt  <= '0;
            gnt_idx <= '0;
            last    <= IW'(NM - 1);
        end else begin
            state   <= state_nx;
            m_bgnt  <= bgnt_nx;
            gnt_idx <= gnt_idx_nx;
            last    <= last_nx;
        end
    end

    assign others = |(m_breq & ~m_bgnt);

    always_comb begin
        state_nx   = state;
        bgnt_nx    = m_bgnt;
        gnt_idx_nx = gnt_idx;
        last_nx    = last;
        s_bstart   = 1'b0;
        finish     = 1'b0;
        fin_err    = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nx   = GRANT;
                    bgnt_nx    = win_oh;
                    gnt_idx_nx = win_idx;
                    last_nx    = win_idx;
                end
            end
            GRANT: begin
                if (m_bstart[gnt_idx]) begin
                    s_bstart = 1'b1;
                    state_nx = BUSY;
                end else if (!m_breq[gnt_idx]) begin
                    bgnt_nx  = '0;
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (s_bdone) begin
                    finish  = 1'b1;
                    fin_err = s_berror;
                end else if (tmo_hit) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end
                // Keep the grant only when nobody else is waiting; otherwise re-arbitrate.
                if (finish) begin
                    if (m_breq[gnt_idx] && !others) begin
                        state_nx = GRANT;
                    end else begin
                        state_nx = IDLE;
                        bgnt_nx  = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                bgnt_nx  = '0;
            end
        endcase
    end

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_tsize = '0;
        if (state != IDLE) begin
            s_addr  = addr_a[gnt_idx];
            s_wdata = wdata_a[gnt_idx];
            s_tsize = tsize_a[gnt_idx];
        end
    end

    assign s_ss     = (state == BUSY) && !tmo_hit;
    assign m_rdata  = s_rdata;
    assign m_bdone  = finish ? m_bgnt : '0;
    assign m_berror = (finish && fin_err) ? m_bgnt : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected events, a negedge monitor checks them.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int NM  = 2;
    localparam int TMO = 8;

    localparam int K_GNT   = 1;
    localparam int K_START = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  tsize;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic               bclk = 1'b0;
    logic               brst_n;
    logic [NM-1:0]      m_breq;
    logic [NM-1:0]      m_bstart;
    logic [NM*32-1:0]   m_addr;
    logic [NM*32-1:0]   m_wdata;
    logic [NM*2-1:0]    m_tsize;
    logic [NM-1:0]      m_bgnt;
    logic [NM-1:0]      m_bdone;
    logic [NM-1:0]      m_berror;
    logic [31:0]        m_rdata;
    logic [31:0]        s_addr;
    logic [31:0]        s_wdata;
    logic [1:0]         s_tsize;
    logic               s_bstart;
    logic               s_ss;
    logic [31:0]        s_rdata;
    logic               s_bdone;
    logic               s_berror;

    bus_arbiter #(
        .NM      (NM),
        .TIMEOUT (TMO)
    ) dut (
        .bclk     (bclk),
        .brst_n   (brst_n),
        .m_breq   (m_breq),
        .m_bstart (m_bstart),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_tsize  (m_tsize),
        .m_bgnt   (m_bgnt),
        .m_bdone  (m_bdone),
        .m_berror (m_berror),
        .m_rdata  (m_rdata),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_tsize  (s_tsize),
        .s_bstart (s_bstart),
        .s_ss     (s_ss),
        .s_rdata  (s_rdata),
        .s_bdone  (s_bdone),
        .s_berror (s_berror)
    );

    always #5 bclk = ~bclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    endtask

    task automatic expect_ev(input int kind, input int idx, input logic [31:0] a,
                             input logic [31:0] w, input logic [1:0] ts, input logic er,
                             input logic [31:0] rd, input logic chk_rd);
        exp_t e;
        e.kind = kind; e.idx = idx; e.addr = a; e.wdata = w; e.tsize = ts;
        e.err = er; e.rdata = rd; e.chk_rd = chk_rd;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, 0);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        case (kind)
            K_GNT: chk("grant_onehot", 32'(m_bgnt), 1 << e.idx);
            K_START: begin
                chk("start_addr", s_addr, e.addr);
                chk("start_wdata", s_wdata, e.wdata);
                chk("start_tsize", 32'(s_tsize), 32'(e.tsize));
                chk("start_gnt", 32'(m_bgnt), 1 << e.idx);
            end
            K_DONE: begin
                chk("done_onehot", 32'(m_bdone), 1 << e.idx);
                chk("done_error", 32'(m_berror), e.err ? (1 << e.idx) : 0);
                if (e.chk_rd) chk("done_rdata", m_rdata, e.rdata);
            end
            default: chk("bad_kind", kind, 0);
        endcase
    endtask

    // Monitor: grant rising edges, forwarded starts and done pulses.
    initial begin
        logic [NM-1:0] prev_bgnt;
        prev_bgnt = '0;
        forever begin
            @(negedge bclk);
            if (brst_n === 1'b1) begin
                if (m_bgnt !== prev_bgnt && m_bgnt !== '0) observe(K_GNT);
                if (s_bstart === 1'b1) observe(K_START);
                if (m_bdone !== '0) observe(K_DONE);
            end
            prev_bgnt = m_bgnt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic set_fields(input int m, input logic [31:0] a, input logic [31:0] w,
                              input logic [1:0] ts);
        m_addr[32*m +: 32]  = a;
        m_wdata[32*m +: 32] = w;
        m_tsize[2*m +: 2]   = ts;
    endtask

    task automatic wait_gnt(input int m);
        int n = 0;
        while (m_bgnt[m] !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("grant_wait", 32'(m_bgnt[m]), 32'h1);
    endtask

    // Master m is in GRANT; start, wait lat BUSY cycles, then slave completes.
    task automatic run_txn(input int m, input logic [31:0] a, input logic [31:0] w,
                           input logic [1:0] ts, input logic [31:0] rd, input logic er,
                           input int lat);
        set_fields(m, a, w, ts);
        expect_ev(K_START, m, a, w, ts, 1'b0, '0, 1'b0);
        m_bstart[m] = 1'b1;
        tick();
        m_bstart[m] = 1'b0;
        chk("busy_ss", 32'(s_ss), 32'h1);
        repeat (lat) tick();
        expect_ev(K_DONE, m, '0, '0, '0, er, rd, 1'b1);
        s_rdata  = rd;
        s_berror = er;
        s_bdone  = 1'b1;
        tick();
        s_bdone  = 1'b0;
        s_berror = 1'b0;
    endtask

    initial begin
        brst_n   = 1'b0;
        m_breq   = '0;
        m_bstart = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_tsize  = '0;
        s_rdata  = '0;
        s_bdone  = 1'b0;
        s_berror = 1'b0;

        tick();
        tick();
        chk("rst_bgnt", 32'(m_bgnt), 0);
        chk("rst_ss", 32'(s_ss), 0);
        chk("rst_sbstart", 32'(s_bstart), 0);
        chk("rst_bdone", 32'(m_bdone), 0);
        chk("rst_berror", 32'(m_berror), 0);
        chk("rst_saddr", s_addr, 0);
        brst_n = 1'b1;
        tick();

        // Single master, errant start from master 1, stray slave done, back-to-back.
        expect_ev(K_GNT, 0, '0, '0, '0, 1'b0, '0, 1'b0);
        m_breq = 2'b01;
        tick();
        chk("req_to_gnt_latency", 32'(m_bgnt), 32'h1);
        m_bstart[1] = 1'b1;
        s_bdone     = 1'b1;
        s_rdata     = 32'hDEAD_BEEF;
        #1;
        chk("errant_no_sbstart", 32'(s_bstart), 0);
        chk("stray_sbdone", 32'(m_bdone), 0);
        tick();
        m_bstart[1] = 1'b0;
        s_bdone     = 1'b0;
        chk("errant_still_gnt", 32'(m_bgnt), 32'h1);
        chk("errant_not_busy", 32'(s_ss), 0);
        run_txn(0, 32'h0000_1000, 32'hA5A5_0001, TSIZE_WORD, 32'hCAFE_F00D, 1'b0, 2);
        chk("b2b_hold_gnt", 32'(m_bgnt), 32'h1);
        chk("b2b_ss_low", 32'(s_ss), 0);
        run_txn(0, 32'h0000_2004, 32'h0000_00EE, TSIZE_BYTE, 32'h1234_5678, 1'b0, 0);
        m_breq = '0;
        tick();
        chk("release_gnt", 32'(m_bgnt), 0);

        // Error path on master 1.
        expect_ev(K_GNT, 1, '0, '0, '0, 1'b0, '0, 1'b0);
        m_breq = 2'b10;
        tick();
        chk("m1_gnt", 32'(m_bgnt), 32'h2);
        run_txn(1, 32'h3000_0010, 32'h0BAD_0BAD, TSIZE_HALF, 32'h0000_0000, 1'b1, 1);
        m_breq = '0;
        tick();
        tick();

        // Reset in the middle of BUSY.
        expect_ev(K_GNT, 0, '0, '0, '0, 1'b0, '0, 1'b0);
        m_breq = 2'b01;
        tick();
        set_fields(0, 32'h0000_5000, 32'h5555_AAAA, TSIZE_WORD);
        expect_ev(K_START, 0, 32'h0000_5000, 32'h5555_AAAA, TSIZE_WORD, 1'b0, '0, 1'b0);
        m_bstart[0] = 1'b1;
        tick();
        m_bstart[0] = 1'b0;
        chk("pre_rst_busy", 32'(s_ss), 32'h1);
        tick();
        brst_n  = 1'b0;
        s_bdone = 1'b1;
        #1;
        chk("midrst_bgnt", 32'(m_bgnt), 0);
        chk("midrst_ss", 32'(s_ss), 0);
        chk("midrst_bdone", 32'(m_bdone), 0);
        chk("midrst_berror", 32'(m_berror), 0);
        chk("midrst_sbstart", 32'(s_bstart), 0);
        tick();
        s_bdone = 1'b0;
        m_breq  = '0;
        brst_n  = 1'b1;
        tick();

        // Contention after reset: strict alternation starting at master 0.
        expect_ev(K_GNT, 0, '0, '0, '0, 1'b0, '0, 1'b0);
        m_breq = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(k % 2);
            chk("rr_order", 32'(m_bgnt), 1 << (k % 2));
            run_txn(k % 2, 32'h4000_0000 + k * 16, 32'h7000_0000 + k, TSIZE_WORD,
                    32'h0100_0000 + k, 1'b0, k);
            if (k < 3) expect_ev(K_GNT, (k + 1) % 2, '0, '0, '0, 1'b0, '0, 1'b0);
        end
        m_breq = '0;
        tick();
        tick();

`ifdef BUS_TIMEOUT_EN
        // Silent slave: forced error on the 8th BUSY cycle, late done ignored.
        expect_ev(K_GNT, 0, '0, '0, '0, 1'b0, '0, 1'b0);
        m_breq = 2'b01;
        tick();
        set_fields(0, 32'h0000_6000, 32'h0000_0066, TSIZE_WORD);
        expect_ev(K_START, 0, 32'h0000_6000, 32'h0000_0066, TSIZE_WORD, 1'b0, '0, 1'b0);
        m_bstart[0] = 1'b1;
        tick();
        m_bstart[0] = 1'b0;
        m_breq      = '0;
        expect_ev(K_DONE, 0, '0, '0, '0, 1'b1, '0, 1'b0);
        repeat (6) tick();
        chk("tmo_not_early", 32'(m_bdone), 0);
        tick();
        chk("tmo_bdone", 32'(m_bdone), 32'h1);
        chk("tmo_berror", 32'(m_berror), 32'h1);
        chk("tmo_ss_drop", 32'(s_ss), 0);
        tick();
        s_bdone = 1'b1;
        #1;
        chk("tmo_late_done", 32'(m_bdone), 0);
        tick();
        s_bdone = 1'b0;
        tick();
`endif

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
